// File: rtl/fpu_denorm_prenorm_pkg.sv
// Shared widths for the denormal pre-normaliser and its leading-zero counter.
package fpu_denorm_prenorm_pkg;
  localparam int FRAC_W = 54;
  localparam int EXP_W  = 12;
  localparam int LZ_W   = $clog2(FRAC_W + 1);
endpackage

// File: rtl/fpu_lzc54.sv
// Combinational 54-bit leading-zero count: 3-bit cells merged 3-to-1, then a final 2-to-1 merge.
// Latency 0; no handshake. An all-zero input reports lz=54, nz=0.
module fpu_lzc54
  import fpu_denorm_prenorm_pkg::*;
(
  input  logic [FRAC_W-1:0] frac,
  output logic [LZ_W-1:0]   lz,
  output logic              nz
);

  logic [17:0] nz0;
  logic [1:0]  c0 [18];
  logic [5:0]  nz1;
  logic [3:0]  c1 [6];
  logic [1:0]  nz2;
  logic [4:0]  c2 [2];

  // Index 0 at every level is the most significant group.
  for (genvar g = 0; g < 18; g++) begin : g_cell
    localparam int HI = FRAC_W - 1 - 3 * g;
    assign nz0[g] = |frac[HI -: 3];
    assign c0[g]  = frac[HI]     ? 2'd0 :
                    frac[HI - 1] ? 2'd1 :
                    frac[HI - 2] ? 2'd2 : 2'd3;
  end

  for (genvar k = 0; k < 6; k++) begin : g_l1
    assign nz1[k] = |nz0[3 * k +: 3];
    assign c1[k]  = nz0[3 * k]     ? {2'b00, c0[3 * k]} :
                    nz0[3 * k + 1] ? 4'd3 + {2'b00, c0[3 * k + 1]} :
                                     4'd6 + {2'b00, c0[3 * k + 2]};
  end

  for (genvar m = 0; m < 2; m++) begin : g_l2
    assign nz2[m] = |nz1[3 * m +: 3];
    assign c2[m]  = nz1[3 * m]     ? {1'b0, c1[3 * m]} :
                    nz1[3 * m + 1] ? 5'd9 + {1'b0, c1[3 * m + 1]} :
                                     5'd18 + {1'b0, c1[3 * m + 2]};
  end

  assign nz = |nz2;
  assign lz = nz2[0] ? {1'b0, c2[0]} : 6'd27 + {1'b0, c2[1]};

endmodule

// File: rtl/fpu_denorm_prenorm.sv
// Two-stage pre-normaliser: left-justifies a denormal fraction and debiases its exponent.
// Latency 2 cycles, 1/cycle throughput; full backpressure, in_rdy is combinational from out_rdy.
module fpu_denorm_prenorm
  import fpu_denorm_prenorm_pkg::*;
(
  input  logic              rclk,
  input  logic              arst_l,
  input  logic              in_vld,
  output logic              in_rdy,
  input  logic [FRAC_W-1:0] in_frac,
  input  logic [EXP_W-1:0]  in_exp,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic [FRAC_W-1:0] out_frac,
  output logic [EXP_W:0]    out_exp,
  output logic [LZ_W-1:0]   out_lz,
  output logic              out_zero
);

  logic              s1_vld, s1_zero;
  logic [FRAC_W-1:0] s1_frac;
  logic [EXP_W-1:0]  s1_exp;
  logic [LZ_W-1:0]   s1_lz;
  logic              s2_vld, s2_zero;
  logic [FRAC_W-1:0] s2_frac;
  logic [EXP_W:0]    s2_exp;
  logic [LZ_W-1:0]   s2_lz;
  logic [LZ_W-1:0]   lzc_lz;
  logic              lzc_nz;
  logic              adv1, adv2, in_fire;

  fpu_lzc54 u_lzc (
    .frac (in_frac),
    .lz   (lzc_lz),
    .nz   (lzc_nz)
  );

  assign adv2    = !s2_vld | out_rdy;
  assign adv1    = !s1_vld | adv2;
  assign in_rdy  = adv1;
  assign in_fire = in_vld & adv1;

  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      s1_vld  <= 1'b0;
      s1_frac <= '0;
      s1_exp  <= '0;
      s1_lz   <= '0;
      s1_zero <= 1'b0;
    end else if (adv1) begin
      s1_vld <= in_vld;
      if (in_vld) begin
        s1_frac <= in_frac;
        s1_exp  <= in_exp;
        s1_lz   <= lzc_lz;
        s1_zero <= !lzc_nz;
      end
    end
  end

  // A zero fraction is forced to frac=0/exp=0 rather than carrying exp-54.
  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      s2_vld  <= 1'b0;
      s2_frac <= '0;
      s2_exp  <= '0;
      s2_lz   <= '0;
      s2_zero <= 1'b0;
    end else if (adv2) begin
      s2_vld <= s1_vld;
      if (s1_vld) begin
        s2_frac <= s1_zero ? '0 : s1_frac << s1_lz;
        s2_exp  <= s1_zero ? '0 :
                   {1'b0, s1_exp} - {{(EXP_W + 1 - LZ_W){1'b0}}, s1_lz};
        s2_lz   <= s1_lz;
        s2_zero <= s1_zero;
      end
    end
  end

  assign out_vld  = s2_vld;
  assign out_frac = s2_frac;
  assign out_exp  = s2_exp;
  assign out_lz   = s2_lz;
  assign out_zero = s2_zero;

  a_normalised: assert property (@(posedge rclk) disable iff (!arst_l)
    (out_vld && !out_zero) |-> out_frac[FRAC_W-1]);

endmodule

// File: tb/tb_fpu_denorm_prenorm.sv
// Bench for fpu_denorm_prenorm: directed corner cases, backpressure ordering, random scoreboard run.
module tb_fpu_denorm_prenorm;
  import fpu_denorm_prenorm_pkg::*;

  typedef struct packed {
    logic [FRAC_W-1:0] frac;
    logic [EXP_W:0]    exp;
    logic [LZ_W-1:0]   lz;
    logic              zero;
  } res_t;

  logic              rclk = 1'b0;
  logic              arst_l = 1'b0;
  logic              in_vld = 1'b0;
  logic              in_rdy;
  logic [FRAC_W-1:0] in_frac = '0;
  logic [EXP_W-1:0]  in_exp = '0;
  logic              out_vld;
  logic              out_rdy = 1'b0;
  logic [FRAC_W-1:0] out_frac;
  logic [EXP_W:0]    out_exp;
  logic [LZ_W-1:0]   out_lz;
  logic              out_zero;

  int   vectors = 0;
  int   miscompares = 0;
  int   n_out = 0;
  res_t sb[$];

  fpu_denorm_prenorm dut (
    .rclk     (rclk),
    .arst_l   (arst_l),
    .in_vld   (in_vld),
    .in_rdy   (in_rdy),
    .in_frac  (in_frac),
    .in_exp   (in_exp),
    .out_vld  (out_vld),
    .out_rdy  (out_rdy),
    .out_frac (out_frac),
    .out_exp  (out_exp),
    .out_lz   (out_lz),
    .out_zero (out_zero)
  );

  always #5 rclk = ~rclk;

  // Reference: shift left until the top bit is set, counting the shifts.
  function automatic res_t model(input logic [FRAC_W-1:0] f, input logic [EXP_W-1:0] e);
    res_t r;
    int   lz;
    lz = 0;
    if (f == '0) begin
      r.frac = '0;
      r.exp  = '0;
      r.lz   = LZ_W'(FRAC_W);
      r.zero = 1'b1;
      return r;
    end
    while (!f[FRAC_W-1]) begin
      f = f << 1;
      lz++;
    end
    r.frac = f;
    r.exp  = (EXP_W + 1)'(int'(e) - lz);
    r.lz   = LZ_W'(lz);
    r.zero = 1'b0;
    return r;
  endfunction

  function automatic res_t observed();
    return {out_frac, out_exp, out_lz, out_zero};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock: drive at posedge+1, sample at negedge, scoreboard on each fire.
  task automatic cycle(input logic v, input logic [FRAC_W-1:0] f, input logic [EXP_W-1:0] e,
                       input logic ordy, output logic fired, output logic rdy_seen);
    in_vld  = v;
    in_frac = f;
    in_exp  = e;
    out_rdy = ordy;
    @(negedge rclk);
    rdy_seen = in_rdy;
    fired    = v & in_rdy;
    if (fired) sb.push_back(model(f, e));
    if (out_vld && !out_zero) check("norm_msb", 128'(out_frac[FRAC_W-1]), 128'(1));
    if (out_vld && out_rdy) begin
      n_out++;
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $error("FAIL unexpected_out observed=%0h expected=none", observed());
      end else begin
        check("out_data", 128'(observed()), 128'(sb.pop_front()));
      end
    end
    @(posedge rclk);
    #1;
  endtask

  task automatic directed(input string tag, input logic [FRAC_W-1:0] f, input logic [EXP_W-1:0] e,
                          input res_t expv);
    in_vld  = 1'b1;
    in_frac = f;
    in_exp  = e;
    out_rdy = 1'b1;
    @(negedge rclk);
    check({tag, "_in_rdy"}, 128'(in_rdy), 128'(1));
    @(posedge rclk);
    #1;
    in_vld = 1'b0;
    @(negedge rclk);
    check({tag, "_not_early"}, 128'(out_vld), 128'(0));
    @(posedge rclk);
    #1;
    @(negedge rclk);
    check({tag, "_out_vld"}, 128'(out_vld), 128'(1));
    check({tag, "_data"}, 128'(observed()), 128'(expv));
    @(posedge rclk);
    #1;
  endtask

  initial begin
    logic              fired, rdy;
    logic [63:0]       r64;
    logic [FRAC_W-1:0] ops_f [4];
    logic [EXP_W-1:0]  ops_e [4];
    int                idx, base, accepted, cyc, d;

    // Reset state
    repeat (2) @(posedge rclk);
    #1;
    check("rst_out_vld", 128'(out_vld), 128'(0));
    check("rst_outputs", 128'(observed()), 128'(0));
    arst_l = 1'b1;
    @(posedge rclk);
    #1;
    check("rst_in_rdy", 128'(in_rdy), 128'(1));

    // Reset with both stages holding operands
    base = n_out;
    cycle(1'b1, 54'h3, 12'h10, 1'b0, fired, rdy);
    cycle(1'b1, 54'h5, 12'h20, 1'b0, fired, rdy);
    arst_l = 1'b0;
    sb.delete();
    #2;
    check("midrst_out_vld", 128'(out_vld), 128'(0));
    @(posedge rclk);
    #1;
    arst_l = 1'b1;
    in_vld = 1'b0;
    @(negedge rclk);
    check("midrst_in_rdy", 128'(in_rdy), 128'(1));
    @(posedge rclk);
    #1;
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, '0, 1'b1, fired, rdy);
    check("midrst_no_stale", 128'(n_out - base), 128'(0));

    // Directed corner cases
    directed("normal", 54'h20_0000_0000_0000, 12'h400,
             {54'h20_0000_0000_0000, 13'h0400, 6'd0, 1'b0});
    directed("lsb_only", 54'h1, 12'h001,
             {54'h20_0000_0000_0000, 13'h1FCC, 6'd53, 1'b0});
    directed("zero", 54'h0, 12'h7FF,
             {54'h0, 13'h0000, 6'd54, 1'b1});
    directed("lz1_neg", 54'h10_0000_0000_0000, 12'h000,
             {54'h20_0000_0000_0000, 13'h1FFF, 6'd1, 1'b0});

    // Four back-to-back operands with a three-cycle output stall
    for (int i = 0; i < 4; i++) begin
      r64 = {$urandom(), $urandom()};
      ops_f[i] = FRAC_W'(r64) >> (3 * i + 1);
      ops_e[i] = EXP_W'($urandom());
    end
    base = n_out;
    idx  = 0;
    for (int c = 0; c < 15; c++) begin
      cycle(idx < 4, ops_f[idx % 4], ops_e[idx % 4], !(c >= 2 && c <= 4), fired, rdy);
      if (c == 1) check("bp_rdy_before_stall", 128'(rdy), 128'(1));
      if (c == 2) check("bp_rdy_dropped", 128'(rdy), 128'(0));
      if (fired) idx++;
    end
    check("bp_all_accepted", 128'(idx), 128'(4));
    check("bp_all_emerged", 128'(n_out - base), 128'(4));
    check("bp_sb_empty", 128'(sb.size()), 128'(0));

    // Random operands and backpressure against the model
    base     = n_out;
    accepted = 0;
    cyc      = 0;
    while (accepted < 10000 && cyc < 40000) begin
      r64 = {$urandom(), $urandom()};
      cycle($urandom_range(0, 3) != 0, FRAC_W'(r64) >> $urandom_range(0, FRAC_W),
            EXP_W'($urandom()), $urandom_range(0, 3) != 0, fired, rdy);
      if (fired) accepted++;
      cyc++;
    end
    check("rand_accepted", 128'(accepted), 128'(10000));
    d = 0;
    while (sb.size() != 0 && d < 100) begin
      cycle(1'b0, '0, '0, 1'b1, fired, rdy);
      d++;
    end
    check("rand_drained", 128'(sb.size()), 128'(0));
    check("rand_out_count", 128'(n_out - base), 128'(accepted));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
